// File: rtl/button_pkg.sv
// Shared types and sizing helpers for the push-button front end.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_e;

  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: synchroniser, stable-count debounce, hold-to-repeat.
module btn_channel
  import button_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 2500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  input  logic repeat_en,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);

  localparam int DW = cnt_width(DEBOUNCE_CYCLES);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD)
                      ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = cnt_width(RMAX);

  localparam logic [DW-1:0] D_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [DW-1:0] D_ONE   = DW'(1);
  localparam logic [RW-1:0] R_DLAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] R_PLAST = RW'(REPEAT_PERIOD - 1);
  localparam logic [RW-1:0] R_ONE   = RW'(1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DW-1:0]          dcnt_q, dcnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;
  rpt_state_e             state_q, state_d;
  logic [RW-1:0]          rcnt_q, rcnt_d;
  logic                   repeat_q, repeat_d;
  logic                   sync;

  assign sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], btn_in};
    dcnt_d    = '0;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sync != level_q) begin
      if (dcnt_q == D_LAST) begin
        level_d   = sync;
        press_d   = sync;
        release_d = ~sync;
      end else begin
        dcnt_d = dcnt_q + D_ONE;
      end
    end
  end

  // A release always wins over a repeat expiring in the same cycle
  always_comb begin
    state_d  = state_q;
    rcnt_d   = rcnt_q;
    repeat_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (press_d) begin
          state_d = DELAY;
          rcnt_d  = '0;
        end
      end
      DELAY: begin
        if (release_d) begin
          state_d = IDLE;
          rcnt_d  = '0;
        end else if (rcnt_q == R_DLAST) begin
          state_d  = REPEAT;
          rcnt_d   = '0;
          repeat_d = repeat_en;
        end else begin
          rcnt_d = rcnt_q + R_ONE;
        end
      end
      REPEAT: begin
        if (release_d) begin
          state_d = IDLE;
          rcnt_d  = '0;
        end else if (rcnt_q == R_PLAST) begin
          rcnt_d   = '0;
          repeat_d = repeat_en;
        end else begin
          rcnt_d = rcnt_q + R_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        rcnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q    <= '0;
      dcnt_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      state_q   <= IDLE;
      rcnt_q    <= '0;
      repeat_q  <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      dcnt_q    <= dcnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
      repeat_q  <= repeat_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_repeat  = repeat_q;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button front end: N_CH independent conditioned channels.
module button_conditioner
  import button_pkg::*;
#(
  parameter int N_CH            = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_PERIOD   = 2500000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] btn_in,
  input  logic [N_CH-1:0] repeat_en,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic [N_CH-1:0] btn_repeat
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .btn_in     (btn_in[i]),
      .repeat_en  (repeat_en[i]),
      .btn_level  (btn_level[i]),
      .btn_press  (btn_press[i]),
      .btn_release(btn_release[i]),
      .btn_repeat (btn_repeat[i])
    );
  end

endmodule
